// File: rtl/accel_sketch_sample_logger_if.sv
// Sample-stream sink and Avalon-MM write-master signals of the sample logger.
// master = logger side, slave = stream source / memory fabric side.
interface accel_sketch_sample_logger_if #(
  parameter int unsigned ADDR_W = 17
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  logic [DATA_W-1:0] snk_data;
  logic              snk_valid;
  logic              snk_ready;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic [BE_W-1:0]   avm_byteenable;
  logic              avm_waitrequest;

  modport master (
    input  snk_data, snk_valid, avm_waitrequest,
    output snk_ready, avm_address, avm_write, avm_writedata, avm_byteenable
  );

  modport slave (
    output snk_data, snk_valid, avm_waitrequest,
    input  snk_ready, avm_address, avm_write, avm_writedata, avm_byteenable
  );
endinterface

// File: rtl/accel_sketch_sample_logger.sv
// Logs a 32-bit sample stream into a circular word buffer through a one-entry
// Avalon-MM write register; reports the write pointer and a sticky wrap flag.
module accel_sketch_sample_logger #(
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned DEPTH_WORDS = 25000,
  localparam int unsigned CNT_W      = 16,
  localparam int unsigned PTR_W      = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ctl_start,
  input  logic                      ctl_stop,
  input  logic [CNT_W-1:0]          ctl_count,
  accel_sketch_sample_logger_if.master bus,
  output logic                      busy,
  output logic                      done,
  output logic                      wrapped,
  output logic [PTR_W-1:0]          wr_ptr
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    accepted_q, accepted_d;
  logic [CNT_W-1:0]    completed_q, completed_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic                wrapped_q, wrapped_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                avm_write_q, avm_write_d;
  logic [ADDR_W-1:0]   avm_address_q, avm_address_d;
  logic [DATA_W-1:0]   avm_writedata_q, avm_writedata_d;
  logic [BE_W-1:0]     avm_byteenable_q, avm_byteenable_d;

  logic                snk_ready_c;
  logic                accept_c;
  logic                complete_c;
  logic                room_c;

  // Handshake qualifiers: the output register can take a new word when it is
  // empty or being emptied this cycle.
  always_comb begin
    room_c      = (count_q == '0) || (accepted_q < count_q);
    snk_ready_c = (state_q == S_RUN) &&
                  (!avm_write_q || !bus.avm_waitrequest) && room_c;
    accept_c    = snk_ready_c && bus.snk_valid;
    complete_c  = avm_write_q && !bus.avm_waitrequest;
  end

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d          = state_q;
    count_d          = count_q;
    accepted_d       = accepted_q;
    completed_d      = completed_q;
    wr_ptr_d         = wr_ptr_q;
    wrapped_d        = wrapped_q;
    avm_write_d      = avm_write_q;
    avm_address_d    = avm_address_q;
    avm_writedata_d  = avm_writedata_q;
    avm_byteenable_d = avm_byteenable_q;
    busy_d           = 1'b0;
    done_d           = 1'b0;

    if (complete_c) begin
      completed_d = completed_q + 1'b1;
      avm_write_d = 1'b0;
      if (wr_ptr_q == PTR_W'(DEPTH_WORDS - 1)) begin
        wr_ptr_d  = '0;
        wrapped_d = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end

    // A new word addresses the slot after any completion happening this cycle.
    if (accept_c) begin
      accepted_d      = accepted_q + 1'b1;
      avm_write_d     = 1'b1;
      avm_writedata_d = bus.snk_data;
      avm_address_d   = ADDR_W'(BASE_ADDR) + ADDR_W'({wr_ptr_d, 2'b00});
    end

    unique case (state_q)
      S_IDLE: begin
        if (ctl_start) begin
          state_d     = S_RUN;
          count_d     = ctl_count;
          accepted_d  = '0;
          completed_d = '0;
          wr_ptr_d    = '0;
          wrapped_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (ctl_stop || ((count_q != '0) && (accepted_d == count_q))) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!avm_write_d) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    avm_byteenable_d = avm_write_d ? {BE_W{1'b1}} : '0;
    busy_d           = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d           = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      count_q          <= '0;
      accepted_q       <= '0;
      completed_q      <= '0;
      wr_ptr_q         <= '0;
      wrapped_q        <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      avm_write_q      <= 1'b0;
      avm_address_q    <= '0;
      avm_writedata_q  <= '0;
      avm_byteenable_q <= '0;
    end else begin
      state_q          <= state_d;
      count_q          <= count_d;
      accepted_q       <= accepted_d;
      completed_q      <= completed_d;
      wr_ptr_q         <= wr_ptr_d;
      wrapped_q        <= wrapped_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      avm_write_q      <= avm_write_d;
      avm_address_q    <= avm_address_d;
      avm_writedata_q  <= avm_writedata_d;
      avm_byteenable_q <= avm_byteenable_d;
    end
  end

  assign bus.snk_ready      = snk_ready_c;
  assign bus.avm_address    = avm_address_q;
  assign bus.avm_write      = avm_write_q;
  assign bus.avm_writedata  = avm_writedata_q;
  assign bus.avm_byteenable = avm_byteenable_q;

  assign busy    = busy_q;
  assign done    = done_q;
  assign wrapped = wrapped_q;
  assign wr_ptr  = wr_ptr_q;
endmodule
